// File: rtl/fusion_stream_pkg.sv
// Shared types and constants for the fused tensor output streamer.
package fusion_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    TS,
    PAYLOAD,
    TRAILER
  } stream_state_e;

  localparam logic [15:0] SYNC_WORD = 16'hF05A;

  localparam int DEF_TENSOR_WIDTH = 2048;
  localparam int DEF_BEAT_WIDTH   = 64;
  localparam int DEF_DEPTH        = 2;
  localparam int ERR_W            = 8;
  localparam int TS_W             = 64;

  // Number of payload beats needed to carry one tensor.
  function automatic int nb_of(input int tensor_width, input int beat_width);
    return tensor_width / beat_width;
  endfunction

  // One captured record as held in a buffer slot.
  typedef struct packed {
    logic [DEF_TENSOR_WIDTH-1:0] tensor;
    logic [ERR_W-1:0]            err;
    logic [TS_W-1:0]             ts;
  } slot_t;

endpackage

// File: rtl/fused_tensor_buffer.sv
// DEPTH-slot register buffer for captured tensor records.
// A pop in the same cycle frees its slot before the push is evaluated.
module fused_tensor_buffer
  import fusion_stream_pkg::*;
#(
  parameter int SLOT_W = DEF_TENSOR_WIDTH + ERR_W + TS_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [SLOT_W-1:0]        wr_data,
  output logic [SLOT_W-1:0]        rd_data,
  output logic [ERR_W-1:0]         rd_next_err,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [SLOT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_next_ptr;
  logic              do_pop;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign do_pop      = pop && !empty;
  assign push_ok     = push && (!full || do_pop);
  assign rd_next_ptr = rd_ptr + 1'b1;
  assign rd_data     = mem[rd_ptr];
  assign rd_next_err = mem[rd_next_ptr][TS_W +: ERR_W];

  // Slot storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fused_tensor_streamer.sv
// Captures fused tensors into a ping-pong buffer and streams each one as a
// framed packet (header, timestamp, payload, XOR trailer) over valid/ready.
module fused_tensor_streamer
  import fusion_stream_pkg::*;
#(
  parameter int TENSOR_WIDTH = DEF_TENSOR_WIDTH,
  parameter int BEAT_WIDTH   = DEF_BEAT_WIDTH,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TENSOR_WIDTH-1:0] tensor_in,
  input  logic                    tensor_valid,
  input  logic [7:0]              err_in,
  input  logic [63:0]             ts_in,
  output logic [BEAT_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [15:0]             drop_count,
  output logic                    overflow,
  output logic                    busy
);

  localparam int NB     = nb_of(TENSOR_WIDTH, BEAT_WIDTH);
  localparam int IW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int SLOT_W = TENSOR_WIDTH + ERR_W + TS_W;
  localparam int CW     = $clog2(DEPTH) + 1;

  stream_state_e           state;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_nxt;
  logic [15:0]             seq;
  logic [BEAT_WIDTH-1:0]   csum;

  logic [SLOT_W-1:0]       rd_data;
  logic [ERR_W-1:0]        rd_next_err;
  logic                    full;
  logic                    empty;
  logic                    push_ok;
  logic [CW-1:0]           count;

  logic                    xfer;
  logic                    pop;
  logic                    pending_after_pop;
  logic [TENSOR_WIDTH-1:0] head_tensor;
  logic [ERR_W-1:0]        head_err;
  logic [TS_W-1:0]         head_ts;
  logic [ERR_W-1:0]        next_err;
  logic [BEAT_WIDTH-1:0]   next_word;

  fused_tensor_buffer #(
    .SLOT_W (SLOT_W),
    .DEPTH  (DEPTH)
  ) u_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (tensor_valid),
    .pop         (pop),
    .wr_data     ({tensor_in, err_in, ts_in}),
    .rd_data     (rd_data),
    .rd_next_err (rd_next_err),
    .full        (full),
    .empty       (empty),
    .push_ok     (push_ok),
    .count       (count)
  );

  function automatic logic [BEAT_WIDTH-1:0] hdr_word(input logic [15:0] s,
                                                     input logic [7:0]  e);
    return BEAT_WIDTH'({SYNC_WORD, s, 8'h00, e, 16'(NB)});
  endfunction

  assign xfer        = m_valid && m_ready;
  assign pop         = xfer && (state == TRAILER);
  assign head_tensor = rd_data[SLOT_W-1 -: TENSOR_WIDTH];
  assign head_err    = rd_data[TS_W +: ERR_W];
  assign head_ts     = rd_data[TS_W-1:0];
  assign idx_nxt     = idx + 1'b1;
  assign next_word   = head_tensor[int'(idx_nxt)*BEAT_WIDTH +: BEAT_WIDTH];

  // With one slot held, the next header's record can only be the tensor
  // arriving in this same cycle, which is not in the slot array yet.
  assign pending_after_pop = (count > CW'(1)) || push_ok;
  assign next_err          = (count > CW'(1)) ? rd_next_err : err_in;

  assign busy = (count != '0) || (state != IDLE);

  // Packet FSM: every output beat is registered one step ahead of its transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      idx     <= '0;
      seq     <= '0;
      csum    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state   <= HDR;
            m_valid <= 1'b1;
            m_data  <= hdr_word(seq, head_err);
          end
        end
        HDR: begin
          csum <= '0;
          if (xfer) begin
            state  <= TS;
            m_data <= BEAT_WIDTH'(head_ts);
          end
        end
        TS: begin
          if (xfer) begin
            state  <= PAYLOAD;
            idx    <= '0;
            m_data <= head_tensor[BEAT_WIDTH-1:0];
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            csum <= csum ^ m_data;
            if (idx == IW'(NB-1)) begin
              idx    <= '0;
              state  <= TRAILER;
              m_last <= 1'b1;
              m_data <= csum ^ m_data;
            end else begin
              idx    <= idx_nxt;
              m_data <= next_word;
            end
          end
        end
        TRAILER: begin
          if (xfer) begin
            seq    <= seq + 16'd1;
            m_last <= 1'b0;
            if (pending_after_pop) begin
              state  <= HDR;
              m_data <= hdr_word(seq + 16'd1, next_err);
            end else begin
              state   <= IDLE;
              m_valid <= 1'b0;
              m_data  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drop accounting for tensors that find the buffer full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (tensor_valid && full && !pop) begin
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fused_tensor_streamer.sv
// Directed bench for fused_tensor_streamer with a packet-level reference model.
module tb_fused_tensor_streamer;

  localparam int TW = 2048;
  localparam int BW = 64;
  localparam int NB = TW / BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [TW-1:0] tensor_in = '0;
  logic          tensor_valid = 1'b0;
  logic [7:0]    err_in = '0;
  logic [63:0]   ts_in = '0;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [15:0]   drop_count;
  logic          overflow;
  logic          busy;

  fused_tensor_streamer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tensor_in    (tensor_in),
    .tensor_valid (tensor_valid),
    .err_in       (err_in),
    .ts_in        (ts_in),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .drop_count   (drop_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  logic [63:0] exp_data[$];
  bit          exp_last[$];
  int          held = 0;
  logic [15:0] mseq = 16'd0;
  int          mdrops = 0;
  bit          movf = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] prev_data = '0;
  bit          prev_last = 1'b0;
  bit          gap_chk = 1'b0;
  int          pkt_beats = 0;
  int          last_pkt_beats = 0;
  logic [15:0] hdr_log[$];
  logic [63:0] beat_log[$];
  logic [63:0] ref_beats[$];

  bit          rdy_mode = 1'b0;
  int          ph = 0;
  bit          rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // A packet as the host must see it: header, timestamp, payload words, XOR trailer.
  task automatic enqueue_packet(input logic [TW-1:0] t, input logic [7:0] e,
                                input logic [63:0] ts, input logic [15:0] s);
    logic [63:0] x;
    logic [63:0] w;
    x = '0;
    exp_data.push_back({16'hF05A, s, 8'h00, e, 16'(NB)}); exp_last.push_back(1'b0);
    exp_data.push_back(ts);                                exp_last.push_back(1'b0);
    for (int k = 0; k < NB; k++) begin
      w = t[k*64 +: 64];
      x = x ^ w;
      exp_data.push_back(w); exp_last.push_back(1'b0);
    end
    exp_data.push_back(x); exp_last.push_back(1'b1);
  endtask

  // Compare process: sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    bit          xfer;
    bit          trailer_xfer;
    logic [63:0] ed;
    bit          el;
    if (!rst_n) begin
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", m_data, 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_drop_count", 64'(drop_count), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      exp_data.delete(); exp_last.delete();
      held = 0; mseq = 16'd0; mdrops = 0; movf = 1'b0;
      stall_prev = 1'b0; gap_chk = 1'b0; pkt_beats = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", 64'(m_last), 64'(prev_last));
      end
      if (gap_chk) chk("no_idle_gap", 64'(m_valid), 64'd1);
      chk("busy", 64'(busy), 64'(held != 0));
      chk("drop_count", 64'(drop_count), 64'(mdrops));
      chk("overflow", 64'(overflow), 64'(movf));
      xfer         = m_valid && m_ready;
      trailer_xfer = xfer && m_last;
      if (xfer) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_beat", m_data, 64'hxxxx_xxxx_xxxx_xxxx);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          chk("beat_data", m_data, ed);
          chk("beat_last", 64'(m_last), 64'(el));
        end
        if (pkt_beats == 0) hdr_log.push_back(m_data[47:32]);
        beat_log.push_back(m_data);
        pkt_beats++;
        if (m_last) begin
          last_pkt_beats = pkt_beats;
          pkt_beats = 0;
        end
      end
      if (tensor_valid) begin
        if (held - (trailer_xfer ? 1 : 0) < 2) begin
          held++;
          enqueue_packet(tensor_in, err_in, ts_in, mseq);
          mseq = mseq + 16'd1;
        end else begin
          if (mdrops < 65535) mdrops++;
          movf = 1'b1;
        end
      end
      if (trailer_xfer) held--;
      gap_chk    = trailer_xfer && (exp_data.size() != 0);
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Ready pattern 1,0,0,1 for the backpressure case.
  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      m_ready = rdy_pat[ph];
      ph = (ph + 1) % 4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [TW-1:0] t, input logic [7:0] e, input logic [63:0] ts);
    tensor_in = t; err_in = e; ts_in = ts; tensor_valid = 1'b1;
    tick();
    tensor_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    hdr_log.delete();
    beat_log.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !m_valid && exp_data.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic wait_last(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_valid && m_last && m_ready) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 64'(done), 64'd1);
  endtask

  function automatic logic [TW-1:0] make_tensor(input int mode);
    logic [TW-1:0] t;
    logic [63:0]   w;
    for (int k = 0; k < NB; k++) begin
      w = 64'h0101_0101_0101_0101 * 64'(k);
      if (mode != 0) w = w ^ {32'(mode), 32'h9E37_79B9 * 32'(mode)};
      t[k*64 +: 64] = w;
    end
    return t;
  endfunction

  initial begin
    logic [TW-1:0] t0;
    bit            done;
    t0 = make_tensor(0);
    #1 rst_n = 1'b0;

    // 1: single tensor, ready held high
    do_reset();
    m_ready = 1'b1;
    send(t0, 8'h03, 64'h1234);
    chk("latency_edge1", 64'(m_valid), 64'd0);
    tick();
    chk("latency_edge2", 64'(m_valid), 64'd1);
    wait_drain("t1_drain", 200);
    chk("t1_beats", 64'(beat_log.size()), 64'd35);
    if (beat_log.size() == 35) begin
      chk("t1_hdr", beat_log[0], 64'hF05A_0000_0003_0020);
      chk("t1_ts", beat_log[1], 64'h0000_0000_0000_1234);
      chk("t1_pay0", beat_log[2], 64'h0);
      chk("t1_pay3", beat_log[5], 64'h0303_0303_0303_0303);
      chk("t1_pay31", beat_log[33], 64'h1F1F_1F1F_1F1F_1F1F);
      chk("t1_trailer", beat_log[34], 64'h0);
    end
    chk("t1_pkt_len", 64'(last_pkt_beats), 64'd35);
    ref_beats = beat_log;

    // 2: backpressure pattern, identical stream expected
    do_reset();
    ph = 0;
    rdy_mode = 1'b1;
    send(t0, 8'h03, 64'h1234);
    wait_drain("t2_drain", 400);
    rdy_mode = 1'b0;
    m_ready = 1'b1;
    chk("t2_beats", 64'(beat_log.size()), 64'(ref_beats.size()));
    if (beat_log.size() == ref_beats.size())
      for (int i = 0; i < ref_beats.size(); i++) chk("t2_same_stream", beat_log[i], ref_beats[i]);

    // 3: overflow with three pulses while stalled
    do_reset();
    m_ready = 1'b0;
    send(make_tensor(1), 8'h11, 64'hA1);
    send(make_tensor(2), 8'h22, 64'hA2);
    send(make_tensor(3), 8'h33, 64'hA3);
    chk("t3_drop_count", 64'(drop_count), 64'd1);
    chk("t3_overflow", 64'(overflow), 64'd1);
    m_ready = 1'b1;
    wait_drain("t3_drain", 400);
    chk("t3_pkts", 64'(hdr_log.size()), 64'd2);
    if (hdr_log.size() == 2) begin
      chk("t3_seq0", 64'(hdr_log[0]), 64'h0);
      chk("t3_seq1", 64'(hdr_log[1]), 64'h1);
    end

    // 4: full buffer, push on the trailer transfer cycle
    do_reset();
    m_ready = 1'b0;
    send(make_tensor(4), 8'h44, 64'hB1);
    send(make_tensor(5), 8'h55, 64'hB2);
    m_ready = 1'b1;
    wait_last("t4_find_trailer", 200);
    send(make_tensor(6), 8'h66, 64'hB3);
    wait_drain("t4_drain", 400);
    chk("t4_no_drop", 64'(drop_count), 64'd0);
    chk("t4_pkts", 64'(hdr_log.size()), 64'd3);
    if (hdr_log.size() == 3) chk("t4_seq2", 64'(hdr_log[2]), 64'h2);

    // 4b: single slot held, push on the trailer cycle continues without a gap
    do_reset();
    m_ready = 1'b1;
    send(make_tensor(7), 8'h77, 64'hC1);
    wait_last("t4b_find_trailer", 200);
    send(make_tensor(8), 8'h5C, 64'hC2);
    wait_drain("t4b_drain", 400);
    chk("t4b_beats", 64'(beat_log.size()), 64'd70);
    if (beat_log.size() == 70) chk("t4b_hdr2", beat_log[35], 64'hF05A_0001_005C_0020);

    // 5: sequence number wrap
    do_reset();
    force dut.seq = 16'hFFFF;
    tick();
    release dut.seq;
    mseq = 16'hFFFF;
    m_ready = 1'b1;
    send(make_tensor(9), 8'h09, 64'hD1);
    send(make_tensor(10), 8'h0A, 64'hD2);
    wait_drain("t5_drain", 400);
    chk("t5_pkts", 64'(hdr_log.size()), 64'd2);
    if (hdr_log.size() == 2) begin
      chk("t5_seq_ffff", 64'(hdr_log[0]), 64'hFFFF);
      chk("t5_seq_0000", 64'(hdr_log[1]), 64'h0);
    end

    // 6: reset while payload beat 10 is presented
    do_reset();
    m_ready = 1'b1;
    send(make_tensor(11), 8'h0B, 64'hE1);
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pkt_beats == 12) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("t6_reach_beat10", 64'(done), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_m_valid", 64'(m_valid), 64'd0);
    chk("t6_m_data", m_data, 64'd0);
    chk("t6_m_last", 64'(m_last), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    hdr_log.delete();
    beat_log.delete();
    send(make_tensor(12), 8'h0C, 64'hE2);
    wait_drain("t6_drain", 200);
    chk("t6_pkts", 64'(hdr_log.size()), 64'd1);
    if (hdr_log.size() == 1) chk("t6_seq0", 64'(hdr_log[0]), 64'h0);
    chk("t6_pkt_len", 64'(last_pkt_beats), 64'd35);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
